pmem_responder: RTL and testbench

PMEM_RESPONDER -- requirements
Module: pmem_responder

---
 rtl/pmem_responder_pkg.sv | 27 ++
 rtl/pmem_line_array.sv | 27 ++
 rtl/pmem_responder.sv | 154 +++++++++++++++
 tb/tb_pmem_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_responder_pkg.sv
// Shared types and constants for the fixed-latency line memory responder.
// Used by pmem_responder and its storage sub-module pmem_line_array.
package pmem_responder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StResp
  } state_e;

  typedef enum logic {
    OpRead,
    OpWrite
  } op_e;

  typedef logic [127:0] line_t;
  typedef logic [15:0]  addr_t;

  localparam int unsigned MaxLatency = 15;
  localparam int unsigned CntBits    = 4;

  // Counter preload so that the response lands exactly `latency` cycles after the request.
  function automatic logic [CntBits-1:0] cnt_load(input int unsigned latency);
    return CntBits'(latency - 1);
  endfunction

endpackage

// File: rtl/pmem_line_array.sv
// Line storage: single-port, synchronous write, combinational read.
// Contents are deliberately not reset.
module pmem_line_array
  import pmem_responder_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] index,
  input  line_t                 wdata,
  output line_t                 rdata
);

  localparam int unsigned Depth = 2 ** INDEX_BITS;

  line_t mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency physical memory responder: accepts a held read/write request,
// counts down LATENCY cycles, then pulses pmem_resp for one cycle.
module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned INDEX_BITS = 8
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  pmem_read,
  input  logic  pmem_write,
  input  addr_t pmem_address,
  input  line_t pmem_wdata,
  output logic  pmem_resp,
  output line_t pmem_rdata,
  output logic  pmem_busy,
  output logic  pmem_error
);

  if (LATENCY < 1 || LATENCY > MaxLatency) begin : g_bad_latency
    $error("pmem_responder: LATENCY out of range 1..15");
  end
  if (INDEX_BITS < 1 || INDEX_BITS > 12) begin : g_bad_index
    $error("pmem_responder: INDEX_BITS out of range 1..12");
  end

  localparam logic [CntBits-1:0] CntLoad = cnt_load(LATENCY);

  state_e                state_q, state_d;
  logic [CntBits-1:0]    cnt_q, cnt_d;
  logic [INDEX_BITS-1:0] index_q;
  op_e                   op_q;
  line_t                 rdata_q;
  logic                  err_q;

  logic  req;
  logic  accept;
  logic  line_we;
  logic  rd_complete;
  line_t line_rdata;

  // Only the index bits of the address matter; offset and high bits alias.
  logic unused_addr;
  assign unused_addr = ^pmem_address;

  assign req    = pmem_read | pmem_write;
  assign accept = (state_q == StIdle) && req;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = (LATENCY == 1) ? StResp : StCount;
        end
      end
      StCount: begin
        // Dropping both request lines cancels the access silently.
        if (!req) begin
          state_d = StIdle;
        end else if (cnt_q <= CntBits'(1)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output logic
  always_comb begin
    pmem_resp   = 1'b0;
    pmem_busy   = 1'b0;
    line_we     = 1'b0;
    rd_complete = 1'b0;
    unique case (state_q)
      StIdle: begin
      end
      StCount: begin
        pmem_busy = 1'b1;
      end
      StResp: begin
        pmem_resp   = 1'b1;
        pmem_busy   = 1'b1;
        line_we     = (op_q == OpWrite) && !reset;
        rd_complete = (op_q == OpRead);
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    cnt_d = '0;
    unique case (state_q)
      StIdle:  cnt_d = accept ? CntLoad : '0;
      StCount: cnt_d = (cnt_q != '0) ? cnt_q - CntBits'(1) : '0;
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      index_q <= '0;
      op_q    <= OpRead;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        index_q <= pmem_address[INDEX_BITS+3:4];
        // A simultaneous read+write is serviced as a write.
        op_q    <= pmem_write ? OpWrite : OpRead;
      end
      if (rd_complete) begin
        rdata_q <= line_rdata;
      end
      if (pmem_read && pmem_write) begin
        err_q <= 1'b1;
      end
    end
  end

  pmem_line_array #(
    .INDEX_BITS (INDEX_BITS)
  ) u_line_array (
    .clk   (clk),
    .we    (line_we),
    .index (index_q),
    .wdata (pmem_wdata),
    .rdata (line_rdata)
  );

  // Read data is visible in the response cycle itself, then held until the next read.
  assign pmem_rdata = rd_complete ? line_rdata : rdata_q;
  assign pmem_error = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder (default LATENCY=4, INDEX_BITS=8) against
// an array model indexed by address/16 modulo the line count.
module tb_pmem_responder;

  localparam int Lat   = 4;
  localparam int Lines = 256;
  localparam logic [127:0] Pat = 128'h0123456789ABCDEF_0123456789ABCDEF;

  logic         clk = 1'b0;
  logic         reset;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         pmem_busy;
  logic         pmem_error;

  logic [127:0] model [Lines];
  logic [127:0] last_rd;
  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pmem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata),
    .pmem_busy    (pmem_busy),
    .pmem_error   (pmem_error)
  );

  function automatic int idx_of(input logic [15:0] a);
    return (int'(a) / 16) % Lines;
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one request from an IDLE cycle, holds it until resp, returns in the next IDLE cycle.
  task automatic run_req(input bit rd, input bit wr, input logic [15:0] a, input logic [127:0] d,
                         input bit scramble, output int lat, output logic [127:0] rdat,
                         output bit busy_ok);
    lat = -1;
    rdat = 'x;
    busy_ok = 1'b1;
    pmem_read = rd;
    pmem_write = wr;
    pmem_address = a;
    pmem_wdata = d;
    for (int j = 1; j <= 3 * Lat + 4 && lat < 0; j++) begin
      @(posedge clk); #1;
      if (scramble && j == 1) pmem_address = 16'($urandom);
      if (!pmem_busy) busy_ok = 1'b0;
      if (pmem_resp) begin
        lat = j;
        rdat = pmem_rdata;
      end
    end
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = '0;
    pmem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (pmem_resp !== 1'b0) $display("FAIL reset_resp got=%b exp=0", pmem_resp); else n_pass++;
    n_total++; if (pmem_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", pmem_busy); else n_pass++;
    n_total++; if (pmem_error !== 1'b0) $display("FAIL reset_error got=%b exp=0", pmem_error); else n_pass++;
    n_total++;
    if (pmem_rdata !== 128'h0) $display("FAIL reset_rdata got=%h exp=0", pmem_rdata); else n_pass++;
    reset = 1'b0;
    last_rd = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    int lat; logic [127:0] r; bit bok; int bad = 0;
    for (int i = 0; i < Lines; i++) begin
      logic [15:0] a;
      a = 16'(i * 16) | 16'($urandom_range(15)) | (16'($urandom_range(15)) << 12);
      model[i] = rand_line();
      run_req(1'b0, 1'b1, a, model[i], 1'b0, lat, r, bok);
      if (lat != Lat || !bok) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL fill_latency bad_ops=%0d exp=0", bad); else n_pass++;
  endtask

  task automatic test_write_read();
    int lat; logic [127:0] r; bit bok;
    run_req(1'b0, 1'b1, 16'h0040, Pat, 1'b0, lat, r, bok);
    model[4] = Pat;
    n_total++; if (lat != Lat) $display("FAIL wr_latency got=%0d exp=%0d", lat, Lat); else n_pass++;
    n_total++;
    if (pmem_rdata !== last_rd) $display("FAIL wr_rdata_hold got=%h exp=%h", pmem_rdata, last_rd);
    else n_pass++;
    run_req(1'b1, 1'b0, 16'h0040, '0, 1'b0, lat, r, bok);
    last_rd = Pat;
    n_total++; if (lat != Lat) $display("FAIL rd_latency got=%0d exp=%0d", lat, Lat); else n_pass++;
    n_total++; if (r !== Pat) $display("FAIL raw_data got=%h exp=%h", r, Pat); else n_pass++;
    n_total++;
    if (pmem_rdata !== Pat) $display("FAIL rd_rdata_hold got=%h exp=%h", pmem_rdata, Pat);
    else n_pass++;
  endtask

  task automatic test_alias();
    int lat; logic [127:0] r; bit bok;
    run_req(1'b1, 1'b0, 16'h0045, '0, 1'b0, lat, r, bok);
    n_total++; if (r !== model[4]) $display("FAIL offset_alias got=%h exp=%h", r, model[4]); else n_pass++;
    run_req(1'b1, 1'b0, 16'h1040, '0, 1'b0, lat, r, bok);
    n_total++; if (r !== model[4]) $display("FAIL high_alias got=%h exp=%h", r, model[4]); else n_pass++;
    last_rd = model[4];
  endtask

  task automatic test_back_to_back();
    int t [$];
    pmem_read = 1'b1;
    pmem_address = 16'h0040;
    for (int j = 1; j <= 3 * (Lat + 1) + 4 && t.size() < 2; j++) begin
      @(posedge clk); #1;
      if (pmem_resp) begin
        t.push_back(j);
        n_total++;
        if (pmem_rdata !== model[4]) $display("FAIL b2b_data got=%h exp=%h", pmem_rdata, model[4]);
        else n_pass++;
      end
    end
    pmem_read = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (t.size() != 2) $display("FAIL b2b_resp_count got=%0d exp=2", t.size());
    else begin
      n_pass++;
      n_total++;
      if (t[0] != Lat) $display("FAIL b2b_first got=%0d exp=%0d", t[0], Lat); else n_pass++;
      n_total++;
      if (t[1] - t[0] != Lat + 1) $display("FAIL b2b_spacing got=%0d exp=%0d", t[1] - t[0], Lat + 1);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int lat; logic [127:0] r; bit bok; int resps;
    for (int k = 0; k < 2; k++) begin
      resps = 0;
      pmem_read = (k == 0);
      pmem_write = (k == 1);
      pmem_address = 16'h0070;
      pmem_wdata = ~model[7];
      repeat (2) begin @(posedge clk); #1; if (pmem_resp) resps++; end
      n_total++; if (pmem_busy !== 1'b1) $display("FAIL abort_busy_pre got=%b exp=1", pmem_busy); else n_pass++;
      pmem_read = 1'b0;
      pmem_write = 1'b0;
      @(posedge clk); #1;
      n_total++; if (pmem_busy !== 1'b0) $display("FAIL abort_busy_post got=%b exp=0", pmem_busy); else n_pass++;
      repeat (6) begin if (pmem_resp) resps++; @(posedge clk); #1; end
      n_total++; if (resps != 0) $display("FAIL abort_no_resp got=%0d exp=0", resps); else n_pass++;
      n_total++;
      if (pmem_rdata !== last_rd) $display("FAIL abort_rdata got=%h exp=%h", pmem_rdata, last_rd);
      else n_pass++;
    end
    run_req(1'b1, 1'b0, 16'h0070, '0, 1'b0, lat, r, bok);
    last_rd = model[7];
    n_total++; if (r !== model[7]) $display("FAIL abort_line got=%h exp=%h", r, model[7]); else n_pass++;
  endtask

  task automatic test_random();
    int lat; logic [127:0] r; bit bok;
    for (int n = 0; n < 60; n++) begin
      bit wr; logic [15:0] a; logic [127:0] d;
      wr = 1'($urandom);
      a = 16'($urandom);
      d = rand_line();
      run_req(!wr, wr, a, d, 1'($urandom), lat, r, bok);
      n_total++;
      if (lat != Lat || !bok) $display("FAIL rand_timing op=%0d lat=%0d exp=%0d busy_ok=%b", n, lat, Lat, bok);
      else n_pass++;
      if (wr) model[idx_of(a)] = d;
      else begin
        n_total++;
        if (r !== model[idx_of(a)])
          $display("FAIL rand_read op=%0d got=%h exp=%h", n, r, model[idx_of(a)]);
        else n_pass++;
        last_rd = model[idx_of(a)];
      end
      n_total++;
      if (pmem_rdata !== last_rd) $display("FAIL rand_hold op=%0d got=%h exp=%h", n, pmem_rdata, last_rd);
      else n_pass++;
    end
  endtask

  task automatic test_error();
    int lat; logic [127:0] r; bit bok; logic [127:0] d;
    d = rand_line();
    n_total++; if (pmem_error !== 1'b0) $display("FAIL err_pre got=%b exp=0", pmem_error); else n_pass++;
    run_req(1'b1, 1'b1, 16'h0080, d, 1'b0, lat, r, bok);
    model[8] = d;
    n_total++; if (lat != Lat) $display("FAIL err_latency got=%0d exp=%0d", lat, Lat); else n_pass++;
    n_total++; if (pmem_error !== 1'b1) $display("FAIL err_set got=%b exp=1", pmem_error); else n_pass++;
    n_total++;
    if (pmem_rdata !== last_rd) $display("FAIL err_rdata_hold got=%h exp=%h", pmem_rdata, last_rd);
    else n_pass++;
    run_req(1'b1, 1'b0, 16'h0080, '0, 1'b0, lat, r, bok);
    last_rd = d;
    n_total++; if (r !== d) $display("FAIL err_write_done got=%h exp=%h", r, d); else n_pass++;
    n_total++; if (pmem_error !== 1'b1) $display("FAIL err_sticky got=%b exp=1", pmem_error); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [127:0] r; bit bok; int resps = 0;
    pmem_write = 1'b1;
    pmem_address = 16'h0040;
    pmem_wdata = ~model[4];
    repeat (2) begin @(posedge clk); #1; if (pmem_resp) resps++; end
    reset = 1'b1;
    @(posedge clk); #1;
    n_total++; if (pmem_resp !== 1'b0) $display("FAIL rstmid_resp got=%b exp=0", pmem_resp); else n_pass++;
    n_total++; if (pmem_busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", pmem_busy); else n_pass++;
    n_total++; if (pmem_error !== 1'b0) $display("FAIL rstmid_error got=%b exp=0", pmem_error); else n_pass++;
    n_total++;
    if (pmem_rdata !== 128'h0) $display("FAIL rstmid_rdata got=%h exp=0", pmem_rdata); else n_pass++;
    reset = 1'b0;
    pmem_write = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (pmem_resp) resps++; end
    n_total++; if (resps != 0) $display("FAIL rstmid_no_resp got=%0d exp=0", resps); else n_pass++;
    run_req(1'b1, 1'b0, 16'h0040, '0, 1'b0, lat, r, bok);
    n_total++; if (r !== model[4]) $display("FAIL rstmid_line got=%h exp=%h", r, model[4]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_abort();
    test_random();
    test_error();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
